lower_part_or_cla_adder16_xor_enc32: RTL and testbench

- Logic-locked 16-bit approximate adder of the lower-part-OR (LOA) type.
- The 4 LSBs are approximated with bitwise OR. The 12 MSBs use a 3-group × 4-bit carry-lookahead adder (CLA).
- 32 key bits are XOR/XNOR gates inserted on internal nets; the result is registered.
- Used as the locked arithmetic block in key-sensitivity (Hamming-distance) experiments. Only the correct key, or an equivalent key, yields the nominal approximate sum.

---
 rtl/lower_part_or_cla_adder16_xor_enc32.sv | 131 +++++++++++++
 tb/tb_lower_part_or_cla_adder16_xor_enc32.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/lower_part_or_cla_adder16_xor_enc32.sv
// lower_part_or_cla_adder16_xor_enc32 : key-locked 16-bit LOA adder (4-bit OR lower part, 3x4 CLA upper part)
// Rev 1.0 -- initial release
`timescale 1ns/1ps
`default_nettype none

module lower_part_or_cla_adder16_xor_enc32 (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [15:0] add1_i,
   input  logic [15:0] add2_i,
   input  logic [31:0] keyinput,
   output logic [16:0] result_o
);

   localparam logic [31:0] C_KC = 32'h1430BA8E;

   // XOR where the correct key bit is 0, XNOR where it is 1.
   function automatic logic lock_gate(input logic net, input logic key_bit, input logic kc_bit);
      lock_gate = kc_bit ? ~(net ^ key_bit) : (net ^ key_bit);
   endfunction

   logic [3:0]  low_sum;
   logic        c4;
   logic [15:4] p_raw;
   logic [15:4] g_raw;
   logic [15:4] p;
   logic [15:4] g;
   logic [15:4] carry;
   logic [2:0]  gg;
   logic [2:0]  gp;
   logic        c8;
   logic        c12;
   logic        c16;
   logic [15:4] carry_lk;
   logic [15:4] sum_hi;
   logic [16:0] result_d;
   logic [16:0] result_q;

   genvar gi;

   generate
      for (gi = 0; gi < 4; gi++) begin : g_low
         assign low_sum[gi] = lock_gate(add1_i[gi] | add2_i[gi], keyinput[gi], C_KC[gi]);
      end
   endgenerate

   assign c4    = lock_gate(add1_i[3] & add2_i[3], keyinput[4], C_KC[4]);
   assign p_raw = add1_i[15:4] ^ add2_i[15:4];
   assign g_raw = add1_i[15:4] & add2_i[15:4];

   assign p[7:4] = p_raw[7:4];
   assign g[7:4] = g_raw[7:4];

   generate
      for (gi = 8; gi < 14; gi++) begin : g_lock_pg_mid
         assign p[gi] = lock_gate(p_raw[gi], keyinput[gi + 2], C_KC[gi + 2]);
         assign g[gi] = lock_gate(g_raw[gi], keyinput[gi + 8], C_KC[gi + 8]);
      end
      for (gi = 14; gi < 16; gi++) begin : g_lock_pg_top
         assign p[gi] = lock_gate(p_raw[gi], keyinput[gi + 8],  C_KC[gi + 8]);
         assign g[gi] = lock_gate(g_raw[gi], keyinput[gi + 10], C_KC[gi + 10]);
      end
   endgenerate

   // Full lookahead inside each 4-bit group; group carry-in is the unlocked carry.
   generate
      for (gi = 0; gi < 3; gi++) begin : g_group
         localparam int B = 4 + 4 * gi;
         assign carry[B + 1] = g[B]
                             | (p[B] & carry[B]);
         assign carry[B + 2] = g[B + 1]
                             | (p[B + 1] & g[B])
                             | (p[B + 1] & p[B] & carry[B]);
         assign carry[B + 3] = g[B + 2]
                             | (p[B + 2] & g[B + 1])
                             | (p[B + 2] & p[B + 1] & g[B])
                             | (p[B + 2] & p[B + 1] & p[B] & carry[B]);
         assign gg[gi] = g[B + 3]
                       | (p[B + 3] & g[B + 2])
                       | (p[B + 3] & p[B + 2] & g[B + 1])
                       | (p[B + 3] & p[B + 2] & p[B + 1] & g[B]);
         assign gp[gi] = &p[B + 3:B];
      end
   endgenerate

   assign c8  = gg[0] | (gp[0] & c4);
   assign c12 = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & c4);
   assign c16 = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0])
              | (gp[2] & gp[1] & gp[0] & c4);

   assign carry[4]  = c4;
   assign carry[8]  = c8;
   assign carry[12] = c12;

   // Locked carries only reach their own sum bit; the lookahead above uses the raw ones.
   always_comb begin
      carry_lk     = carry;
      carry_lk[5]  = lock_gate(carry[5], keyinput[6], C_KC[6]);
      carry_lk[6]  = lock_gate(carry[6], keyinput[7], C_KC[7]);
      carry_lk[7]  = lock_gate(carry[7], keyinput[8], C_KC[8]);
      carry_lk[8]  = lock_gate(lock_gate(carry[8], keyinput[5], C_KC[5]), keyinput[9], C_KC[9]);
      carry_lk[12] = lock_gate(carry[12], keyinput[26], C_KC[26]);
   end

   always_comb begin
      sum_hi = p ^ carry_lk;
      for (int i = 12; i < 16; i++) begin
         sum_hi[i] = lock_gate(p[i] ^ carry_lk[i], keyinput[i + 16], C_KC[i + 16]);
      end
   end

   always_comb begin
      result_d        = '0;
      result_d[3:0]   = low_sum;
      result_d[15:4]  = sum_hi;
      result_d[16]    = lock_gate(c16, keyinput[27], C_KC[27]);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         result_q <= '0;
      end else begin
         result_q <= result_d;
      end
   end

   assign result_o = result_q;

endmodule

`default_nettype wire

// File: tb/tb_lower_part_or_cla_adder16_xor_enc32.sv
// tb_lower_part_or_cla_adder16_xor_enc32 : randomized bench against a ripple-form model of the locked adder
// Rev 1.0 -- initial release
`timescale 1ns/1ps
`default_nettype none

module tb_lower_part_or_cla_adder16_xor_enc32;

   localparam logic [31:0] C_KC    = 32'h1430BA8E;
   localparam logic [31:0] C_EQUIV = 32'h1430B8AE;
   localparam int          N_RAND  = 1500;

   logic        clk;
   logic        rst_n;
   logic [15:0] add1;
   logic [15:0] add2;
   logic [31:0] key;
   logic [16:0] result;

   int errors;
   int checks;

   lower_part_or_cla_adder16_xor_enc32 dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .add1_i   (add1),
      .add2_i   (add2),
      .keyinput (key),
      .result_o (result)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Nominal approximate sum: OR on the low nibble, exact add with a3&b3 carried into the top 12 bits.
   function automatic logic [16:0] approx_sum(input logic [15:0] a, input logic [15:0] b);
      logic [12:0] up;
      up = {1'b0, a[15:4]} + {1'b0, b[15:4]} + {12'b0, a[3] & b[3]};
      approx_sum = {up, a[3:0] | b[3:0]};
   endfunction

   // Locked netlist: each key bit that differs from KC inverts its net; carries ripple bit by bit.
   function automatic logic [16:0] ref_model(input logic [15:0] a, input logic [15:0] b,
                                             input logic [31:0] k);
      logic [31:0] d;
      logic [16:0] r;
      logic [15:0] p;
      logic [15:0] g;
      logic        c;
      logic        cflip;
      logic        sflip;
      d = k ^ C_KC;
      r = '0;
      for (int j = 0; j < 4; j++) r[j] = (a[j] | b[j]) ^ d[j];
      c = (a[3] & b[3]) ^ d[4];
      p = a ^ b;
      g = a & b;
      for (int i = 8; i < 14; i++) begin
         p[i] = p[i] ^ d[i + 2];
         g[i] = g[i] ^ d[i + 8];
      end
      p[14] = p[14] ^ d[22];
      p[15] = p[15] ^ d[23];
      g[14] = g[14] ^ d[24];
      g[15] = g[15] ^ d[25];
      for (int i = 4; i < 16; i++) begin
         case (i)
            5:       cflip = d[6];
            6:       cflip = d[7];
            7:       cflip = d[8];
            8:       cflip = d[5] ^ d[9];
            12:      cflip = d[26];
            default: cflip = 1'b0;
         endcase
         sflip = (i >= 12) ? d[i + 16] : 1'b0;
         r[i]  = p[i] ^ c ^ cflip ^ sflip;
         c     = g[i] | (p[i] & c);
      end
      r[16] = c ^ d[27];
      ref_model = r;
   endfunction

   task automatic apply(input logic [15:0] a, input logic [15:0] b, input logic [31:0] k);
      @(negedge clk);
      add1 = a;
      add2 = b;
      key  = k;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      add1  = 16'hFFF8;
      add2  = 16'h0008;
      key   = C_KC;
      #2;
      checks++;
      if (result !== 17'h0) begin
         errors++;
         $display("FAIL reset_initial: got %h expected %h", result, 17'h0);
      end
      @(posedge clk);
      #1;
      checks++;
      if (result !== 17'h0) begin
         errors++;
         $display("FAIL reset_held: got %h expected %h", result, 17'h0);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      checks++;
      if (result !== 17'h10008) begin
         errors++;
         $display("FAIL reset_first_capture: got %h expected %h", result, 17'h10008);
      end
   endtask

   task automatic test_reset_mid_run;
      apply(16'h0F0F, 16'h00F1, C_KC);
      checks++;
      if (result !== 17'h00FFF) begin
         errors++;
         $display("FAIL midrun_before_reset: got %h expected %h", result, 17'h00FFF);
      end
      #1;
      rst_n = 1'b0;
      #1;
      checks++;
      if (result !== 17'h0) begin
         errors++;
         $display("FAIL midrun_async_clear: got %h expected %h", result, 17'h0);
      end
      @(posedge clk);
      #1;
      checks++;
      if (result !== 17'h0) begin
         errors++;
         $display("FAIL midrun_reset_held: got %h expected %h", result, 17'h0);
      end
      @(negedge clk);
      rst_n = 1'b1;
      add1  = 16'hFFFF;
      add2  = 16'h0001;
      @(posedge clk);
      #1;
      checks++;
      if (result !== 17'h0FFFF) begin
         errors++;
         $display("FAIL midrun_release: got %h expected %h", result, 17'h0FFFF);
      end
   endtask

   task automatic test_directed;
      logic [15:0] va [5];
      logic [15:0] vb [5];
      logic [16:0] ve [5];
      logic [31:0] ks [2];
      va = '{16'h0F0F, 16'hFFF8, 16'h0008, 16'hFFFF, 16'h0000};
      vb = '{16'h00F1, 16'h0008, 16'h0008, 16'h0001, 16'h0000};
      ve = '{17'h00FFF, 17'h10008, 17'h00018, 17'h0FFFF, 17'h00000};
      ks = '{C_KC, C_EQUIV};
      for (int k = 0; k < 2; k++) begin
         for (int v = 0; v < 5; v++) begin
            apply(va[v], vb[v], ks[k]);
            checks++;
            if (result !== ve[v]) begin
               errors++;
               $display("FAIL directed key=%h a=%h b=%h: got %h expected %h",
                        ks[k], va[v], vb[v], result, ve[v]);
            end
         end
      end
   endtask

   task automatic test_single_flip;
      logic [31:0] k;
      logic [16:0] exp;
      apply(16'h0000, 16'h0000, 32'h1430BA0E);
      checks++;
      if (result !== 17'h00040) begin
         errors++;
         $display("FAIL flip_k7_zero: got %h expected %h", result, 17'h00040);
      end
      apply(16'h0000, 16'h0000, 32'h1430BA8C);
      checks++;
      if (result !== 17'h00002) begin
         errors++;
         $display("FAIL flip_k1_zero: got %h expected %h", result, 17'h00002);
      end
      for (int bitn = 0; bitn < 32; bitn++) begin
         k    = C_KC ^ (32'h1 << bitn);
         add1 = 16'($urandom);
         add2 = 16'($urandom);
         exp  = ref_model(add1, add2, k);
         apply(add1, add2, k);
         checks++;
         if (result !== exp) begin
            errors++;
            $display("FAIL flip_bit%0d a=%h b=%h: got %h expected %h", bitn, add1, add2, result, exp);
         end
      end
   endtask

   task automatic test_random_sweep;
      logic [31:0] keys [8];
      logic [15:0] a;
      logic [15:0] b;
      logic [16:0] exp;
      int          differ;
      keys = '{C_KC, C_EQUIV, 32'h1430BA0E, 32'h1430BA8C, 32'h1430BA00,
               32'h6330BA8E, 32'h143FEA8E, 32'hEBCF4571};
      for (int k = 0; k < 8; k++) begin
         differ = 0;
         for (int n = 0; n < N_RAND; n++) begin
            a   = 16'($urandom);
            b   = 16'($urandom);
            exp = ref_model(a, b, keys[k]);
            apply(a, b, keys[k]);
            checks++;
            if (result !== exp) begin
               errors++;
               $display("FAIL sweep_model key=%h a=%h b=%h: got %h expected %h",
                        keys[k], a, b, result, exp);
            end
            if (k < 2) begin
               checks++;
               if (result !== approx_sum(a, b)) begin
                  errors++;
                  $display("FAIL sweep_approx key=%h a=%h b=%h: got %h expected %h",
                           keys[k], a, b, result, approx_sum(a, b));
               end
            end else if (result !== approx_sum(a, b)) begin
               differ++;
            end
         end
         if (k >= 2) begin
            checks++;
            if (differ == 0) begin
               errors++;
               $display("FAIL key_sensitivity key=%h: got %0d corrupted outputs expected >0",
                        keys[k], differ);
            end
         end
      end
   endtask

   initial begin
      errors = 0;
      checks = 0;
      test_reset();
      test_directed();
      test_single_flip();
      test_reset_mid_run();
      test_random_sweep();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire
